// File: rtl/first_one_isolator.sv
// Registered lowest-set-bit isolator: one-hot mask, binary index and found flag,
// captured one cycle behind data_valid.
module first_one_isolator #(
    parameter int WIDTH = 8
) (
    input  logic                                        clock,
    input  logic                                        resetn,
    input  logic                                        data_valid,
    input  logic [WIDTH-1:0]                            data,
    output logic [WIDTH-1:0]                            first_one,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] first_one_index,
    output logic                                        found,
    output logic                                        result_valid
);

    localparam int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]       w_first_one;
    logic [INDEX_WIDTH-1:0] w_index;
    logic                   w_found;

    logic [WIDTH-1:0]       r_first_one;
    logic [INDEX_WIDTH-1:0] r_index;
    logic                   r_found;
    logic                   r_result_valid;

    // Isolate the lowest set bit; two's-complement trick keeps only that bit.
    always_comb begin
        w_first_one = data & (~data + WIDTH'(1'b1));
        w_found     = |data;
    end

    // One-hot to binary: OR together the positions of set bits (at most one is set).
    always_comb begin
        w_index = {INDEX_WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_index = w_index | (w_first_one[i] ? INDEX_WIDTH'(i) : {INDEX_WIDTH{1'b0}});
        end
    end

    // Result register: capture on valid, hold otherwise; result_valid pulses per capture.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_first_one    <= {WIDTH{1'b0}};
            r_index        <= {INDEX_WIDTH{1'b0}};
            r_found        <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= data_valid;
            if (data_valid) begin
                r_first_one <= w_first_one;
                r_index     <= w_index;
                r_found     <= w_found;
            end else begin
                r_first_one <= r_first_one;
                r_index     <= r_index;
                r_found     <= r_found;
            end
        end
    end

    assign first_one       = r_first_one;
    assign first_one_index = r_index;
    assign found           = r_found;
    assign result_valid    = r_result_valid;

endmodule

// File: tb/tb_first_one_isolator.sv
// Randomized and directed checks of first_one_isolator at WIDTH 8, 1, 5 and 16
// against a bit-scanning reference model.
module tb_first_one_isolator;

    localparam int NI = 4;
    localparam int WIDTHS [NI] = '{8, 1, 5, 16};

    logic clock;
    logic resetn;

    int checks;
    int errors;

    logic        cur_v  [NI];
    logic [31:0] cur_d  [NI];
    logic [31:0] exp_fo [NI];
    logic [31:0] exp_idx[NI];
    logic        exp_fd [NI];
    logic        exp_rv [NI];
    logic [31:0] obs_fo [NI];
    logic [31:0] obs_idx[NI];
    logic        obs_fd [NI];
    logic        obs_rv [NI];

    logic [7:0]  fo8;  logic [2:0] ix8;  logic fd8;  logic rv8;
    logic [0:0]  fo1;  logic [0:0] ix1;  logic fd1;  logic rv1;
    logic [4:0]  fo5;  logic [2:0] ix5;  logic fd5;  logic rv5;
    logic [15:0] fo16; logic [3:0] ix16; logic fd16; logic rv16;

    first_one_isolator #(.WIDTH(8)) u_dut8 (
        .clock(clock), .resetn(resetn), .data_valid(cur_v[0]), .data(cur_d[0][7:0]),
        .first_one(fo8), .first_one_index(ix8), .found(fd8), .result_valid(rv8));
    first_one_isolator #(.WIDTH(1)) u_dut1 (
        .clock(clock), .resetn(resetn), .data_valid(cur_v[1]), .data(cur_d[1][0:0]),
        .first_one(fo1), .first_one_index(ix1), .found(fd1), .result_valid(rv1));
    first_one_isolator #(.WIDTH(5)) u_dut5 (
        .clock(clock), .resetn(resetn), .data_valid(cur_v[2]), .data(cur_d[2][4:0]),
        .first_one(fo5), .first_one_index(ix5), .found(fd5), .result_valid(rv5));
    first_one_isolator #(.WIDTH(16)) u_dut16 (
        .clock(clock), .resetn(resetn), .data_valid(cur_v[3]), .data(cur_d[3][15:0]),
        .first_one(fo16), .first_one_index(ix16), .found(fd16), .result_valid(rv16));

    assign obs_fo[0] = {24'd0, fo8};  assign obs_idx[0] = {29'd0, ix8};
    assign obs_fo[1] = {31'd0, fo1};  assign obs_idx[1] = {31'd0, ix1};
    assign obs_fo[2] = {27'd0, fo5};  assign obs_idx[2] = {29'd0, ix5};
    assign obs_fo[3] = {16'd0, fo16}; assign obs_idx[3] = {28'd0, ix16};
    assign obs_fd[0] = fd8; assign obs_fd[1] = fd1; assign obs_fd[2] = fd5; assign obs_fd[3] = fd16;
    assign obs_rv[0] = rv8; assign obs_rv[1] = rv1; assign obs_rv[2] = rv5; assign obs_rv[3] = rv16;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: scan upward from bit 0; the first 1 found wins.
    function automatic void ref_fn(input int w, input logic [31:0] d,
                                   output logic [31:0] fo, output logic [31:0] idx,
                                   output logic fd);
        fo = 32'd0; idx = 32'd0; fd = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (d[i] && !fd) begin
                fd  = 1'b1;
                idx = i;
                fo  = 32'd1 << i;
            end
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check_eq($sformatf("w%0d_first_one", WIDTHS[k]), obs_fo[k], exp_fo[k]);
            check_eq($sformatf("w%0d_index", WIDTHS[k]), obs_idx[k], exp_idx[k]);
            check_eq($sformatf("w%0d_found", WIDTHS[k]), {31'd0, obs_fd[k]}, {31'd0, exp_fd[k]});
            check_eq($sformatf("w%0d_result_valid", WIDTHS[k]), {31'd0, obs_rv[k]}, {31'd0, exp_rv[k]});
        end
    endtask

    task automatic zero_model();
        for (int k = 0; k < NI; k++) begin
            exp_fo[k] = 32'd0; exp_idx[k] = 32'd0; exp_fd[k] = 1'b0; exp_rv[k] = 1'b0;
        end
    endtask

    // One cycle: check results of the previous drive, then drive the W8 stimulus
    // plus random stimulus to the other widths and advance the model.
    task automatic step(input logic v8, input logic [7:0] d8);
        logic [31:0] fo, idx;
        logic        fd;
        @(negedge clock);
        check_all();
        cur_v[0] = v8;
        cur_d[0] = {24'd0, d8};
        for (int k = 1; k < NI; k++) begin
            cur_v[k] = ($urandom_range(0, 3) != 0);
            cur_d[k] = $urandom & ((32'd1 << WIDTHS[k]) - 32'd1);
        end
        for (int k = 0; k < NI; k++) begin
            if (cur_v[k]) begin
                ref_fn(WIDTHS[k], cur_d[k], fo, idx, fd);
                exp_fo[k] = fo; exp_idx[k] = idx; exp_fd[k] = fd;
            end
            exp_rv[k] = cur_v[k];
        end
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear before any edge.
    task automatic reset_pulse();
        step(1'b0, 8'h00);
        #2;
        resetn = 1'b0;
        for (int k = 0; k < NI; k++) cur_v[k] = 1'b0;
        zero_model();
        #1;
        check_all();
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            cur_v[k] = 1'b0;
            cur_d[k] = 32'd0;
        end
        zero_model();
        repeat (2) @(negedge clock);
        check_all();
        resetn = 1'b1;
        repeat (3) step(1'b0, 8'h00);

        // Exhaustive W8 sweep back-to-back, with random traffic on the other widths
        for (int v = 0; v < 256; v++) step(1'b1, 8'(v));
        step(1'b1, 8'h68);
        step(1'b1, 8'h00);
        step(1'b1, 8'h80);
        step(1'b1, 8'hFF);

        // Hold behaviour
        step(1'b1, 8'h14);
        repeat (3) step(1'b0, 8'h01);

        // Mid-stream reset, then fresh capture
        step(1'b1, 8'h55);
        reset_pulse();
        repeat (2) step(1'b0, 8'h00);
        step(1'b1, 8'h30);
        step(1'b0, 8'h00);

        // Random traffic on all widths
        for (int n = 0; n < 300; n++) step($urandom_range(0, 3) != 0, 8'($urandom));
        step(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/first_one_isolator.md
Name:
first_one_isolator

Overview:
- Registered first-one (lowest-set-bit) isolator.
- Takes a WIDTH-bit vector and returns a one-hot mask of its least-significant set bit, plus the binary index of that bit and a found flag.
- Results are registered once behind an input valid qualifier.
- Used in arbiters, allocators and free-slot finders wherever the lowest-priority-index requester must be selected.

Parameters:
- WIDTH, 8, width of the input vector and of the one-hot output; legal range ≥1.
- INDEX_WIDTH, derived = max(1, $clog2(WIDTH)), width of the binary index output; not overridable.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- data_valid  input  1  qualifies data for capture this cycle
- data  input  WIDTH  vector to search
- first_one  output  WIDTH  one-hot mask of the lowest set bit of captured data; all-zero if none set
- first_one_index  output  INDEX_WIDTH  binary position of that bit
- found  output  1  1 when captured data had at least one bit set
- result_valid  output  1  outputs updated on the previous clock edge

Behaviour:
- Priority: bit 0 is highest priority. Scan is from LSB upward; the lowest-index set bit wins.
- first_one combinational function: first_one[i] = data[i] AND NOT(data[i-1:0] has any 1). This is equivalent to data & (~data + 1), truncated to WIDTH.
- first_one_index: binary encoding of the single set bit of the one-hot result.
- found: OR-reduction of data.
- Zero input: first_one = all-zero, first_one_index = 0, found = 0.
- Exactly one bit of first_one is set whenever found = 1; none is set otherwise.
- Register stage:
  - On a rising clock edge with data_valid = 1: first_one, first_one_index and found capture the function of data; result_valid <= 1.
  - On a rising edge with data_valid = 0: first_one, first_one_index and found hold their previous values; result_valid <= 0.
- Latency: exactly 1 clock from data_valid/data sampled to result_valid/outputs. Throughput is one vector per cycle; back-to-back valids are allowed with no bubbles.
- Reset: resetn low asynchronously forces first_one = 0, first_one_index = 0, found = 0, result_valid = 0, independent of clock.
- Reset release: the first capture occurs on the first rising edge with resetn high and data_valid = 1.
- Reset asserted mid-stream: any pending result is discarded; no output pulses on release.
- No backpressure: the consumer must accept a result in the cycle result_valid is high.
- WIDTH = 1: first_one = data, first_one_index is always 0, found = data.
- All-ones input: first_one = 1 (bit 0 set), index = 0.
- Only-MSB input: first_one = 1 << (WIDTH-1), index = WIDTH-1.
- No X propagation from unused logic: outputs are fully defined after reset for all legal inputs.

Test Plan:
- Reset check: assert resetn low mid-cycle with outputs nonzero -> all outputs 0 immediately, without waiting for a clock edge. Release and hold data_valid = 0 -> result_valid stays 0.
- Exhaustive, WIDTH = 8: drive all 256 data values back-to-back with data_valid = 1. Each result appears one cycle later with result_valid = 1 and is compared against a reference model (e.g. 8'b0110_1000 -> first_one 8'b0000_1000, index 3, found 1; 8'b1111_1111 -> 8'b0000_0001, index 0).
- Boundaries: data = 8'h00 -> first_one 8'h00, index 0, found 0, result_valid 1. data = 8'h80 -> first_one 8'h80, index 7, found 1.
- Hold behaviour: capture 8'b0001_0100 (-> 8'b0000_0100, index 2), then drive data_valid = 0 with data = 8'h01 for 3 cycles -> outputs stay 8'b0000_0100 / index 2 / found 1, result_valid 0.
- Mid-stream reset: pulse resetn low between two valid captures -> outputs 0. The next valid input (e.g. 8'h30) yields 8'h10, index 4 one cycle after capture.
- Parameter sweep: WIDTH = 1, 5, 16 with random data -> results match the reference model. WIDTH = 1 index is always 0.
